// File: rtl/tan_arbiter.sv
// Round-robin front end that shares one iterative tan engine among N_REQ requesters.
// Handshake: a requester raises req[i] with a stable angle, gets a one-cycle ack[i], and drops req[i] the next cycle.
module tan_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int W       = 32,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_angle,
    output logic [N_REQ-1:0]   ack,
    output logic [W-1:0]       rsp_tan,
    output logic               rsp_err,
    output logic [ID_W-1:0]    rsp_id,
    output logic               busy,
    output logic [W-1:0]       eng_xita,
    input  logic               eng_valid,
    input  logic [W-1:0]       eng_tan,
    output logic [1:0]         dbg_state_o
);

    localparam int SET_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [W-1:0]      rsp_tan_q, rsp_tan_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              busy_q, busy_d;
    logic [W-1:0]      xita_q, xita_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [W-1:0]      grant_angle;
    int                cand;

    // First pending requester at or after ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_angle = '0;
        cand        = 0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = (int'(ptr_q) + off) % N_REQ;
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
                grant_angle = req_angle[cand*W +: W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        set_cnt_d = set_cnt_q;
        to_cnt_d  = to_cnt_q;
        ack_d     = ack_q;
        rsp_tan_d = rsp_tan_q;
        rsp_err_d = rsp_err_q;
        rsp_id_d  = rsp_id_q;
        busy_d    = busy_q;
        xita_d    = xita_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    xita_d    = grant_angle;
                    rsp_id_d  = grant_idx;
                    set_cnt_d = '0;
                    to_cnt_d  = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // The engine's valid still reflects the previous angle here.
                set_cnt_d = set_cnt_q + 1'b1;
                if (set_cnt_q == SET_LAST) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_valid) begin
                    rsp_tan_d = eng_tan;
                    rsp_err_d = 1'b0;
                    ack_d     = ONE_HOT0 << rsp_id_q;
                    state_d   = S_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    rsp_tan_d = '0;
                    rsp_err_d = 1'b1;
                    ack_d     = ONE_HOT0 << rsp_id_q;
                    state_d   = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ack_d   = '0;
                busy_d  = 1'b0;
                ptr_d   = (rsp_id_q == ID_LAST) ? '0 : rsp_id_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // eng_xita is only rewritten on a grant so the engine never restarts spuriously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            set_cnt_q <= '0;
            to_cnt_q  <= '0;
            ack_q     <= '0;
            rsp_tan_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_id_q  <= '0;
            busy_q    <= 1'b0;
            xita_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            set_cnt_q <= set_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ack_q     <= ack_d;
            rsp_tan_q <= rsp_tan_d;
            rsp_err_q <= rsp_err_d;
            rsp_id_q  <= rsp_id_d;
            busy_q    <= busy_d;
            xita_q    <= xita_d;
        end
    end

    assign ack         = ack_q;
    assign rsp_tan     = rsp_tan_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_id      = rsp_id_q;
    assign busy        = busy_q;
    assign eng_xita    = xita_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tan_arbiter.sv
// Directed bench for tan_arbiter: instance a uses a behavioural engine, instance b (TIMEOUT=16) has a hand-driven engine.
module tb_tan_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]   a_req;
    logic [N*W-1:0] a_angle;
    logic [N-1:0]   a_ack;
    logic [W-1:0]   a_tan;
    logic           a_err;
    logic [1:0]     a_id;
    logic           a_busy;
    logic [W-1:0]   a_xita;
    logic           a_eng_valid;
    logic [W-1:0]   a_eng_tan;
    logic [1:0]     a_state;

    logic [N-1:0]   b_req;
    logic [N*W-1:0] b_angle;
    logic [N-1:0]   b_ack;
    logic [W-1:0]   b_tan;
    logic           b_err;
    logic [1:0]     b_id;
    logic           b_busy;
    logic [W-1:0]   b_xita;
    logic           b_eng_valid;
    logic [W-1:0]   b_eng_tan;
    logic [1:0]     b_state;

    int checks = 0;
    int errors = 0;
    int lat = 10;

    tan_arbiter #(.N_REQ(N), .ID_W(2), .W(W), .SETTLE(2), .TIMEOUT(4096)) u_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .req_angle(a_angle), .ack(a_ack),
        .rsp_tan(a_tan), .rsp_err(a_err), .rsp_id(a_id), .busy(a_busy),
        .eng_xita(a_xita), .eng_valid(a_eng_valid), .eng_tan(a_eng_tan),
        .dbg_state_o(a_state)
    );

    tan_arbiter #(.N_REQ(N), .ID_W(2), .W(W), .SETTLE(2), .TIMEOUT(16)) u_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .req_angle(b_angle), .ack(b_ack),
        .rsp_tan(b_tan), .rsp_err(b_err), .rsp_id(b_id), .busy(b_busy),
        .eng_xita(b_xita), .eng_valid(b_eng_valid), .eng_tan(b_eng_tan),
        .dbg_state_o(b_state)
    );

    // Engine model: sees an angle change one edge late, then result = angle ^ 0x0F0F after lat cycles.
    logic [W-1:0] m_prev_x;
    logic         m_run;
    int           m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev_x    <= '0;
            m_run       <= 1'b0;
            m_cnt       <= 0;
            a_eng_valid <= 1'b0;
            a_eng_tan   <= '0;
        end else begin
            m_prev_x <= a_xita;
            if (a_xita != m_prev_x) begin
                a_eng_valid <= 1'b0;
                m_run       <= 1'b1;
                m_cnt       <= 0;
            end else if (m_run) begin
                if (m_cnt == lat - 1) begin
                    a_eng_valid <= 1'b1;
                    a_eng_tan   <= a_xita ^ 32'h0000_0F0F;
                    m_run       <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // k counts edges from the grant edge (k=1) to the edge on which ack was seen.
    task automatic wait_ack_a(output int k);
        k = 0;
        do begin
            @(posedge clk);
            k++;
            #1;
        end while (a_ack == '0 && k < 200);
    endtask

    task automatic serve_a(input int id, input logic [W-1:0] ang, input int latency,
                           output int k);
        a_angle[id*W +: W] = ang;
        lat = latency;
        @(negedge clk);
        a_req = N'(1) << id;
        wait_ack_a(k);
        a_req = '0;
        @(posedge clk);
        #1;
        check("ack_one_cycle", a_ack, 0);
        check("busy_fall", a_busy, 0);
    endtask

    logic [W-1:0] fair_tan [4] = '{32'h0000_0F1F, 32'h0000_0F2F, 32'h0000_0F3F, 32'h0000_0F4F};
    int k;
    int ack_seen;

    initial begin
        rst_n       = 1'b0;
        a_req       = '0;
        a_angle     = '0;
        b_req       = '0;
        b_angle     = '0;
        b_eng_valid = 1'b0;
        b_eng_tan   = '0;
        #1;
        check("rst_ack", a_ack, 0);
        check("rst_tan", a_tan, 0);
        check("rst_err", a_err, 0);
        check("rst_id", a_id, 0);
        check("rst_busy", a_busy, 0);
        check("rst_xita", a_xita, 0);
        check("rst_state", a_state, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all four requesting continuously.
        a_angle = {32'h40, 32'h30, 32'h20, 32'h10};
        lat = 10;
        @(negedge clk);
        a_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack_a(k);
            check("rr_lat", 64'(k), (i == 0) ? 64'd13 : 64'd14);
            check("rr_ack", a_ack, 64'(4'b0001 << (i % 4)));
            check("rr_id", a_id, 64'(i % 4));
            check("rr_tan", a_tan, 64'(fair_tan[i % 4]));
            check("rr_err", a_err, 0);
        end
        a_req = '0;
        @(posedge clk);
        #1;
        check("rr_busy_fall", a_busy, 0);

        // Single request with a slow engine.
        serve_a(0, 32'h0000_4000, 24, k);
        check("single_lat", 64'(k), 27);
        check("single_tan", a_tan, 32'h0000_4F0F);
        check("single_id", a_id, 0);
        check("single_err", a_err, 0);

        // Stale valid: engine still shows 0x1111 when the next angle is granted.
        serve_a(1, 32'h0000_1E1E, 10, k);
        check("stale_prev_tan", a_tan, 32'h0000_1111);
        serve_a(2, 32'h0000_2D2D, 10, k);
        check("stale_lat", 64'(k), 13);
        check("stale_tan", a_tan, 32'h0000_2222);
        check("stale_id", a_id, 2);

        // Same angle twice: the engine keeps valid high, minimum latency.
        serve_a(3, 32'h0000_0100, 10, k);
        check("same1_tan", a_tan, 32'h0000_0E0F);
        serve_a(0, 32'h0000_0100, 10, k);
        check("same2_lat", 64'(k), 4);
        check("same2_tan", a_tan, 32'h0000_0E0F);
        check("same2_id", a_id, 0);

        // Timeout on instance b: engine never valid.
        b_angle[2*W +: W] = 32'h0000_0777;
        @(negedge clk);
        b_req = 4'b0100;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            #1;
        end while (b_ack == '0 && k < 200);
        b_req = '0;
        check("to_lat", 64'(k), 19);
        check("to_ack", b_ack, 4'b0100);
        check("to_err", b_err, 1);
        check("to_tan", b_tan, 0);
        check("to_id", b_id, 2);
        @(posedge clk);
        #1;
        check("to_busy_fall", b_busy, 0);

        // Valid arriving on the last WAIT count wins over the timeout.
        b_angle[1*W +: W] = 32'h0000_0333;
        b_eng_tan = 32'h0000_BEEF;
        @(negedge clk);
        b_req = 4'b0010;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            #1;
            if (k == 18) b_eng_valid = 1'b1;
        end while (b_ack == '0 && k < 200);
        b_req = '0;
        b_eng_valid = 1'b0;
        check("late_lat", 64'(k), 19);
        check("late_err", b_err, 0);
        check("late_tan", b_tan, 32'h0000_BEEF);
        check("late_id", b_id, 1);

        // Reset in the middle of WAIT.
        serve_a(2, 32'h0000_0500, 10, k);
        check("pre_rst_tan", a_tan, 32'h0000_0A0F);
        a_angle[3*W +: W] = 32'h0000_0600;
        lat = 24;
        @(negedge clk);
        a_req = 4'b1000;
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy", a_busy, 1);
        check("mid_state", a_state, 2);
        check("mid_xita", a_xita, 32'h0000_0600);
        check("mid_id", a_id, 3);
        #2;
        rst_n = 1'b0;
        a_req = '0;
        #1;
        check("arst_ack", a_ack, 0);
        check("arst_tan", a_tan, 0);
        check("arst_err", a_err, 0);
        check("arst_id", a_id, 0);
        check("arst_busy", a_busy, 0);
        check("arst_xita", a_xita, 0);
        check("arst_state", a_state, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (a_ack != '0) ack_seen++;
        end
        check("no_ack_after_rst", 64'(ack_seen), 0);

        // Pointer restarts at 0 after reset, so requester 1 wins over 3.
        a_angle[1*W +: W] = 32'h0000_0700;
        a_angle[3*W +: W] = 32'h0000_0800;
        lat = 10;
        @(negedge clk);
        a_req = 4'b1010;
        wait_ack_a(k);
        a_req = '0;
        check("post_lat", 64'(k), 13);
        check("post_ack", a_ack, 4'b0010);
        check("post_id", a_id, 1);
        check("post_tan", a_tan, 32'h0000_080F);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tan_arbiter.md
# tan_arbiter

Round-robin scheduler that shares one iterative `tan` CORDIC engine among `N_REQ` requesters. It sits between the angle-producing blocks and the engine's `xita`/`valid`/`tan` port. It grants one request at a time and drives the granted angle into the engine. It guards against the engine's stale `valid`, then returns the result (or a timeout error) to the granted requester with a one-cycle `ack`.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: width of `rsp_id`; requires 2^ID_W ≥ N_REQ.
- `W`, default 32: angle/result width; opaque to this block.
- `SETTLE`, default 2: cycles spent waiting after loading an angle before `eng_valid` is trusted; minimum 2.
- `TIMEOUT`, default 4096: maximum number of WAIT cycles before an error response.

- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, N_REQ: per-requester request level.
- `req_angle`, in, N_REQ*W: angle of requester i in bits [i*W +: W]. Must be stable while `req[i]` is high.
- `ack`, out, N_REQ: one-hot, one-cycle completion pulse.
- `rsp_tan`, out, W: result; valid in the `ack` cycle and held until the next `ack`.
- `rsp_err`, out, 1: high with `ack` when the request timed out.
- `rsp_id`, out, ID_W: index of the requester being served or last served.
- `busy`, out, 1: high while a request is in flight.
- `eng_xita`, out, W: angle driven to the engine.
- `eng_valid`, in, 1: engine result-valid level.
- `eng_tan`, in, W: engine result.

## Operation
- FSM states: IDLE, SETTLE, WAIT, DONE. All outputs are registered.
- **IDLE**
  - If any `req` bit is set, select the first set bit searching from `ptr` upward, modulo N_REQ.
  - Load `eng_xita`←angle[g] and `rsp_id`←g.
  - Clear `set_cnt` and `to_cnt`, set `busy`←1, and go to SETTLE.
  - Otherwise hold all outputs.
- **SETTLE**
  - Increment `set_cnt`. When `set_cnt` = SETTLE−1, go to WAIT.
  - `eng_valid` is ignored here. The engine only detects an angle change one edge later, so its `valid` is stale during this window.
- **WAIT**
  - If `eng_valid`=1: `rsp_tan`←`eng_tan`, `rsp_err`←0, `ack[g]`←1, go to DONE.
  - Else if `to_cnt` = TIMEOUT−1: `rsp_tan`←0, `rsp_err`←1, `ack[g]`←1, go to DONE.
  - Else increment `to_cnt`.
  - `eng_valid` wins over timeout on the same edge.
- **DONE**
  - `ack`←0, `busy`←0, `ptr`←(g+1) mod N_REQ, go to IDLE.
- **Requester rule:** deassert `req[i]` in the cycle after seeing `ack[i]`.
  - A requester still holding `req` is served again only after all other pending requesters, because `ptr` has moved past it.
- **Same angle as the previous request:** the engine does not restart and its `valid` stays high with the correct result. The result is returned at minimum latency; this is correct behaviour.
- **After a timeout:** the engine keeps running. The next grant overwrites `eng_xita`, which restarts the engine.
- `eng_xita` is held from grant until the next grant. It is never cleared in IDLE, which avoids spurious engine restarts.
- Reset values: `ack`=0, `rsp_tan`=0, `rsp_err`=0, `rsp_id`=0, `busy`=0, `eng_xita`=0, `ptr`=0, state=IDLE.
- Reset asserted mid-operation returns the block to IDLE immediately. No `ack` is issued for the aborted request. The engine shares `rst_n`.

## Timing
- Edge E0 (IDLE, `req` sampled) to `ack` high: at least SETTLE+1 edges, i.e. 3 with the defaults.
- In the general case `ack` rises on the first WAIT edge with `eng_valid`=1.
- Timeout `ack` rises on edge E0+SETTLE+TIMEOUT.
- `ack` is high for exactly one cycle; `busy` falls on the edge after `ack` rises.
- Earliest next grant is the edge after DONE. Back-to-back throughput is SETTLE+3 edges per request at minimum engine latency.
- Requests arriving while `busy` wait; none are dropped.

## Test plan
- **Single request:** `req`=0001, angle 0x0000_4000, engine model with valid after 24 cycles.
  - Expect `ack`=0001 once, with `rsp_tan`=model value, `rsp_err`=0, `rsp_id`=0.
- **Round-robin fairness:** `req`=1111 held continuously, model latency 10.
  - Expect grant order 0,1,2,3,0; each `ack` one-hot.
- **Stale-valid guard:** model holds `valid`=1 with old result 0x1111 until 1 cycle after `eng_xita` changes, then outputs new result 0x2222 after 10 cycles.
  - Expect `rsp_tan`=0x2222, never 0x1111.
- **Same angle twice:** serve angle 0x100, then request 0x100 again with `valid` held high.
  - Expect the second `ack` exactly 3 edges after its grant edge, same `rsp_tan`.
- **Timeout:** TIMEOUT=16, model never asserts `valid`.
  - Expect `ack` at E0+18 with `rsp_err`=1 and `rsp_tan`=0.
  - Then `valid` at WAIT count 15: expect `rsp_err`=0.
- **Reset mid-WAIT:** assert `rst_n`=0 during WAIT.
  - Expect all outputs at reset values asynchronously, and no `ack` after release until a new request completes.
